// File: rtl/serial_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_mem_bridge_if
// Purpose  : Bundles the pad-side byte streams (rx/tx), the status flags and
//            the req/ack word memory port of serial_mem_bridge.
// Modports : slave  - the bridge itself (consumes rx, produces tx and mem_*)
//            master - the environment (pads + memory fabric)
// Signals  : rx_data/rx_valid, tx_data/tx_valid/tx_ready, busy, overrun,
//            mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack
// Revision : 1.0  initial release
// ============================================================================
interface serial_mem_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        output tx_data, tx_valid, busy, overrun,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        input  tx_data, tx_valid, busy, overrun,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/serial_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : serial_mem_bridge
// Purpose  : Reassembles byte-serial access frames (CMD, 4 addr bytes, 4 wdata
//            bytes for writes, all LSB first) into one word access on a
//            req/ack memory port, then returns a status byte followed, for
//            reads, by 4 read-data bytes LSB first.
// Ports    : clk, rst (async, active high)
//            bus (serial_mem_bridge_if.slave): rx stream in, tx stream out
//            with ready handshake, busy/overrun flags, word memory port.
// Revision : 1.0  initial release
// ============================================================================
module serial_mem_bridge #(
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] OK_CODE  = 8'hA5,
    parameter logic [7:0] ERR_CODE = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mem_bridge_if.slave    bus
);

    localparam int                    c_TMO_W    = $clog2(TIMEOUT + 1);
    // Last MEM cycle that may still see an ack; an ack here wins over expiry.
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_WDATA = 3'd2;
    localparam logic [2:0] c_MEM   = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;

    logic [2:0]         state_q,       state_d;
    logic [1:0]         cnt_q,         cnt_d;
    logic [c_TMO_W-1:0] tmo_q,         tmo_d;
    logic [7:0]         tx_data_q,     tx_data_d;
    logic               tx_valid_q,    tx_valid_d;
    logic               overrun_q,     overrun_d;
    logic               mem_req_q,     mem_req_d;
    logic               mem_we_q,      mem_we_d;
    logic [31:0]        mem_addr_q,    mem_addr_d;
    logic [31:0]        mem_wdata_q,   mem_wdata_d;
    logic [31:0]        rdata_q,       rdata_d;
    logic               stat_sent_q,   stat_sent_d;   // status byte already handed over

    logic [1:0]         w_next_idx;
    assign w_next_idx = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        overrun_d   = overrun_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        stat_sent_d = stat_sent_q;

        case (state_q)
            c_IDLE: begin
                if (bus.rx_valid) begin
                    mem_we_d = bus.rx_data[0];
                    cnt_d    = 2'd0;
                    state_d  = c_ADDR;
                end
            end

            c_ADDR: begin
                if (bus.rx_valid) begin
                    mem_addr_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = w_next_idx;
                    if (cnt_q == 2'd3) begin
                        if (mem_we_q) begin
                            state_d = c_WDATA;
                        end else begin
                            state_d   = c_MEM;
                            mem_req_d = 1'b1;
                            tmo_d     = '0;
                        end
                    end
                end
            end

            c_WDATA: begin
                if (bus.rx_valid) begin
                    mem_wdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = w_next_idx;
                    if (cnt_q == 2'd3) begin
                        state_d   = c_MEM;
                        mem_req_d = 1'b1;
                        tmo_d     = '0;
                    end
                end
            end

            c_MEM: begin
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (bus.mem_ack || (tmo_q == c_TMO_LAST)) begin
                    mem_req_d   = 1'b0;
                    tmo_d       = '0;
                    tx_valid_d  = 1'b1;
                    stat_sent_d = 1'b0;
                    state_d     = c_RESP;
                    if (bus.mem_ack) begin
                        tx_data_d = OK_CODE;
                        if (!mem_we_q) begin
                            rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        tx_data_d = ERR_CODE;
                        rdata_d   = 32'd0;
                    end
                end else begin
                    tmo_d = tmo_q + c_TMO_W'(1);
                end
            end

            c_RESP: begin
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (tx_valid_q && bus.tx_ready) begin
                    if (!stat_sent_q && !mem_we_q) begin
                        stat_sent_d = 1'b1;
                        cnt_d       = 2'd0;
                        tx_data_d   = rdata_q[7:0];
                    end else if (stat_sent_q && (cnt_q != 2'd3)) begin
                        cnt_d     = w_next_idx;
                        tx_data_d = rdata_q[{w_next_idx, 3'b000} +: 8];
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = c_IDLE;
                    end
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            cnt_q       <= 2'd0;
            tmo_q       <= '0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            stat_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            overrun_q   <= overrun_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            stat_sent_q <= stat_sent_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = (state_q != c_IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
